// File: rtl/sram_1rw_req_adapter_if.sv
// Request/response/SRAM-side bundle for sram_1rw_req_adapter.
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid does not depend on ready, and ready_and_o does not depend
// on v_i or w_i.
interface sram_1rw_req_adapter_if #(
  parameter int width_p      = 64,
  parameter int addr_width_p = 9
);
  // request side
  logic                    v_i;
  logic                    w_i;
  logic [addr_width_p-1:0] addr_i;
  logic [width_p-1:0]      data_i;
  logic [width_p-1:0]      w_mask_i;
  logic                    ready_and_o;
  // response side
  logic                    v_o;
  logic [width_p-1:0]      data_o;
  logic                    ready_and_i;
  // SRAM side
  logic                    ce_o;
  logic                    we_o;
  logic [addr_width_p-1:0] addr_o;
  logic [width_p-1:0]      wd_o;
  logic [width_p-1:0]      w_mask_o;
  logic [width_p-1:0]      rd_i;

  // adapter view
  modport slave (
    input  v_i, w_i, addr_i, data_i, w_mask_i, ready_and_i, rd_i,
    output ready_and_o, v_o, data_o, ce_o, we_o, addr_o, wd_o, w_mask_o
  );

  // environment view (requester, consumer and SRAM)
  modport master (
    output v_i, w_i, addr_i, data_i, w_mask_i, ready_and_i, rd_i,
    input  ready_and_o, v_o, data_o, ce_o, we_o, addr_o, wd_o, w_mask_o
  );
endinterface

// File: rtl/sram_1rw_req_adapter.sv
// Valid/ready front end for a 1RW synchronous SRAM. Requests go straight to
// the SRAM in the cycle they are accepted; read data (one cycle later) is
// captured into a 2-entry response FIFO. ready_and_o only admits a request
// when the FIFO is guaranteed to have room for every read still in flight.
module sram_1rw_req_adapter #(
  parameter int width_p      = 64,
  parameter int els_p        = 512,
  parameter int addr_width_p = 9
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  sram_1rw_req_adapter_if.slave        bus
);

  if (els_p > (1 << addr_width_p)) begin : g_bad_params
    $error("els_p does not fit in addr_width_p address bits");
  end

  logic [1:0]         occ_q, occ_d;
  logic               wptr_q, rptr_q;
  logic               rd_pending_q;
  logic [width_p-1:0] fifo_q [2];

  logic               accept;
  logic               deq;
  logic               enq;
  logic [2:0]         committed;

  // Slots already spoken for once this cycle's dequeue leaves: stored
  // entries plus the read whose data arrives this cycle.
  always_comb begin
    deq       = (occ_q != 2'd0) & bus.ready_and_i;
    committed = {1'b0, occ_q} + {2'b00, rd_pending_q} - {2'b00, deq};
    enq       = rd_pending_q;
    occ_d     = occ_q + {1'b0, enq} - {1'b0, deq};
  end

  assign bus.ready_and_o = ~reset_i & (committed < 3'd2);
  assign accept          = bus.v_i & bus.ready_and_o;

  assign bus.ce_o     = accept;
  assign bus.we_o     = accept & bus.w_i;
  assign bus.addr_o   = bus.addr_i;
  assign bus.wd_o     = bus.data_i;
  assign bus.w_mask_o = bus.w_i ? bus.w_mask_i : '0;

  assign bus.v_o    = (occ_q != 2'd0);
  assign bus.data_o = fifo_q[rptr_q];

  // Control state: occupancy, pointers and the read-in-flight flag.
  // Reset wins over a pending read, so its data is dropped.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      occ_q        <= 2'd0;
      wptr_q       <= 1'b0;
      rptr_q       <= 1'b0;
      rd_pending_q <= 1'b0;
    end else begin
      occ_q        <= occ_d;
      rd_pending_q <= accept & ~bus.w_i;
      if (enq) wptr_q <= ~wptr_q;
      if (deq) rptr_q <= ~rptr_q;
    end
  end

  // Response storage, intentionally not reset; capture SRAM read data.
  always_ff @(posedge clk_i) begin
    if (enq & ~reset_i) fifo_q[wptr_q] <= bus.rd_i;
  end

endmodule

// File: tb/tb_sram_1rw_req_adapter.sv
// Directed and random bench for sram_1rw_req_adapter with a behavioural SRAM,
// a reference memory and an expected-response queue.
module tb_sram_1rw_req_adapter;
  localparam int W = 32;
  localparam int E = 16;
  localparam int A = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_i;
  always #5 clk = ~clk;

  sram_1rw_req_adapter_if #(.width_p(W), .addr_width_p(A)) bus ();

  sram_1rw_req_adapter #(.width_p(W), .els_p(E), .addr_width_p(A)) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .bus     (bus)
  );

  // behavioural 1RW SRAM: read data valid the cycle after the read issue
  logic [W-1:0] sram_mem [E];
  logic [W-1:0] rd_q;
  always @(posedge clk) begin
    if (bus.ce_o) begin
      if (bus.we_o)
        sram_mem[bus.addr_o] <= (sram_mem[bus.addr_o] & ~bus.w_mask_o) | (bus.wd_o & bus.w_mask_o);
      else
        rd_q <= sram_mem[bus.addr_o];
    end
  end
  assign bus.rd_i = rd_q;

  // ---------------- scoreboard ----------------
  logic [W-1:0] ref_mem [E];
  logic [W-1:0] exp_q [$];
  int           checks = 0;
  int           errors = 0;
  int           pops   = 0;
  logic [W-1:0] last_pop = '0;
  logic         s_acc, s_vo, s_rdy;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Drive one cycle of inputs, sample at the falling edge, score, advance.
  task automatic drive(input logic v, input logic w, input logic [A-1:0] a,
                       input logic [W-1:0] d, input logic [W-1:0] m, input logic rdy);
    logic [W-1:0] e;
    bus.v_i = v; bus.w_i = w; bus.addr_i = a;
    bus.data_i = d; bus.w_mask_i = m; bus.ready_and_i = rdy;
    @(negedge clk);
    s_acc = bus.v_i & bus.ready_and_o;
    s_vo  = bus.v_o;
    s_rdy = bus.ready_and_o;
    chk("ce_vs_accept", bus.ce_o, s_acc);
    chk("we", bus.we_o, s_acc & w);
    if (v && !w) chk("rd_mask_zero", bus.w_mask_o, '0);
    if (reset_i) begin
      exp_q.delete();
    end else begin
      if (s_vo === 1'b1 && rdy) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL resp_without_request observed=%0h expected=none", bus.data_o);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("resp_data", bus.data_o, e);
          last_pop = bus.data_o;
          pops++;
        end
      end else if (s_vo === 1'b1 && exp_q.size() != 0) begin
        chk("hold_data", bus.data_o, exp_q[0]);
      end
      if (s_acc) begin
        if (w) ref_mem[a] = (ref_mem[a] & ~m) | (d & m);
        else   exp_q.push_back(ref_mem[a]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, 1'b0, '0, '0, '0, rdy);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  int acc_cnt;
  int pops_before;
  initial begin
    reset_i = 1'b1;
    bus.v_i = 1'b0; bus.w_i = 1'b0; bus.addr_i = '0;
    bus.data_i = '0; bus.w_mask_i = '0; bus.ready_and_i = 1'b0;
    @(posedge clk); #1;

    // reset holds off requests even with v_i high
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, '0, '0, '1, 1'b1);
      chk("rst_ready", s_rdy, 1'b0);
    end
    reset_i = 1'b0;
    idle(1'b1);
    chk("post_rst_vo", s_vo, 1'b0);
    chk("post_rst_ready", s_rdy, 1'b1);

    // prefill every word so both memories agree
    for (int i = 0; i < E; i++) begin
      ref_mem[i] = '0;
      drive(1'b1, 1'b1, A'(i), W'(32'h0101_0101 * i), '1, 1'b1);
    end
    chk("prefill_acc", s_acc, 1'b1);

    // write then read addr 5, latency 2
    drive(1'b1, 1'b1, 4'd5, 32'hDEAD_BEEF, '1, 1'b1);
    drive(1'b1, 1'b0, 4'd5, '0, '0, 1'b1);
    chk("rd5_acc", s_acc, 1'b1);
    idle(1'b1);
    chk("rd5_vo_n1", s_vo, 1'b0);
    idle(1'b1);
    chk("rd5_vo_n2", s_vo, 1'b1);
    chk("rd5_data", last_pop, 32'hDEAD_BEEF);

    // partial-mask write
    drive(1'b1, 1'b1, 4'd7, 32'h0, '1, 1'b1);
    drive(1'b1, 1'b1, 4'd7, 32'hFFFF, 32'h00FF, 1'b1);
    drive(1'b1, 1'b0, 4'd7, '0, '0, 1'b1);
    for (int i = 0; i < 3; i++) idle(1'b1);
    chk("mask_data", last_pop, 32'h00FF);

    // back-to-back reads at full rate
    acc_cnt = 0;
    pops_before = pops;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, A'(i), '0, '0, 1'b1);
      acc_cnt += int'(s_acc);
    end
    chk("b2b_accepts", acc_cnt, 10);
    for (int i = 0; i < 3; i++) idle(1'b1);
    chk("b2b_resps", pops - pops_before, 10);

    // consumer stalled: only two reads fit
    acc_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, A'(i + 1), '0, '0, 1'b0);
      acc_cnt += int'(s_acc);
    end
    chk("stall_accepts", acc_cnt, 2);
    chk("stall_ready", s_rdy, 1'b0);
    chk("stall_vo", s_vo, 1'b1);
    for (int i = 0; i < 4; i++) idle(1'b1);
    chk("stall_drained", exp_q.size(), 0);

    // reset right after a read accept
    drive(1'b1, 1'b0, 4'd3, '0, '0, 1'b1);
    chk("rst_rd_acc", s_acc, 1'b1);
    reset_i = 1'b1;
    drive(1'b1, 1'b0, 4'd4, '0, '0, 1'b1);
    chk("midrst_ready", s_rdy, 1'b0);
    reset_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      chk("after_rst_vo", s_vo, 1'b0);
    end
    chk("after_rst_ready", s_rdy, 1'b1);

    // random mix
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), A'($urandom_range(0, E - 1)),
            W'($urandom), W'($urandom), ($urandom_range(0, 3) != 0));
    end
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) idle(1'b1);
    chk("drain_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sram_1rw_req_adapter.md
SRAM_1RW_REQ_ADAPTER -- requirements
Module: sram_1rw_req_adapter

Interface
REQ-001 SHALL have parameter width_p, default 64, data word width in bits.
REQ-002 SHALL have parameter els_p, default 512, number of SRAM words.
REQ-003 SHALL have parameter addr_width_p, default 9, equal to log2(els_p).
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset_i, input, 1, synchronous active-high reset.
REQ-007 SHALL have port v_i, input, 1, request valid.
REQ-008 SHALL have port w_i, input, 1, request type: 1 write, 0 read.
REQ-009 SHALL have port addr_i, input, addr_width_p, request word address.
REQ-010 SHALL have port data_i, input, width_p, write data.
REQ-011 SHALL have port w_mask_i, input, width_p, per-bit write enable.
REQ-012 SHALL have port ready_and_o, output, 1, adapter accepts a request this cycle.
REQ-013 SHALL have port v_o, output, 1, read response valid.
REQ-014 SHALL have port data_o, output, width_p, read response data.
REQ-015 SHALL have port ready_and_i, input, 1, consumer accepts the response.
REQ-016 SHALL have port ce_o, output, 1, SRAM chip enable.
REQ-017 SHALL have port we_o, output, 1, SRAM write enable.
REQ-018 SHALL have port addr_o, output, addr_width_p, SRAM address.
REQ-019 SHALL have port wd_o, output, width_p, SRAM write data.
REQ-020 SHALL have port w_mask_o, output, width_p, SRAM bit write mask.
REQ-021 SHALL have port rd_i, input, width_p, SRAM read data, valid the cycle after a read issue.

Function
REQ-022 SHALL accept a request in any cycle where v_i & ready_and_o (accept).
REQ-023 SHALL drive ce_o = accept combinationally, so the SRAM samples the request at the same clock edge.
REQ-024 SHALL drive we_o = accept & w_i, addr_o = addr_i, wd_o = data_i, and w_mask_o = w_i ? w_mask_i : 0.
REQ-025 SHALL treat writes as fire-and-forget: no response is generated.
REQ-026 SHALL hold one flag, rd_pending, set on the edge after a read accept; otherwise it is cleared.
REQ-027 SHALL enqueue rd_i into a 2-entry response FIFO at the clock edge that ends any cycle in which rd_pending=1.
REQ-028 SHALL present the FIFO head on data_o with v_o = (occupancy != 0); deq = v_o & ready_and_i.
REQ-029 SHALL drive ready_and_o = ~reset_i & (occupancy + rd_pending - deq < 2), independent of v_i and w_i.
REQ-030 SHALL never overflow the FIFO: an enqueue while occupancy=2 and deq=0 is impossible by REQ-029.
REQ-031 SHALL handle simultaneous enqueue and dequeue: occupancy unchanged, order preserved.
REQ-032 SHALL use 1-bit read/write pointers that wrap modulo 2; occupancy ranges 0..2.
REQ-033 SHALL return read responses in request order, with a minimum latency of 2 cycles: accept in cycle n, v_o in cycle n+2.
REQ-034 SHALL sustain one read accept per cycle when ready_and_i is held at 1.
REQ-035 SHALL pass back-to-back write-then-read to the same address to the SRAM unmodified, and return the newly written data.
REQ-036 SHALL keep data_o stable while v_o=1 and ready_and_i=0.

Reset
REQ-037 SHALL, while reset_i=1, force ready_and_o=0 and ce_o=0 combinationally.
REQ-038 SHALL, at the reset edge, clear occupancy, pointers and rd_pending, giving v_o=0 in the first cycle after reset.
REQ-039 SHALL discard any read in flight when reset is asserted mid-operation: rd_i in the following cycle is not enqueued.
REQ-040 SHALL leave FIFO data storage unreset; data_o is don't-care while v_o=0.

Verification
REQ-041 SHALL cover: write addr 5 data 0xDEAD_BEEF mask all-ones, then read addr 5 -> v_o two cycles after the read accept, data_o=0xDEAD_BEEF.
REQ-042 SHALL cover: write addr 7 = 0x0, then write 0xFFFF with mask 0x00FF, then read addr 7 -> data_o=0x00FF.
REQ-043 SHALL cover: reads to addrs 0..9 back-to-back with ready_and_i=1 -> 10 accepts in 10 cycles and 10 in-order responses.
REQ-044 SHALL cover: reads issued with ready_and_i=0 -> exactly 2 accepts, then ready_and_o=0; data_o holds the first response until ready_and_i rises.
REQ-045 SHALL cover: read accepted, reset asserted the next cycle -> v_o=0 after reset, no stale response, ready_and_o=1 once reset deasserts.
REQ-046 SHALL cover: random valid/ready and read/write mix against a reference memory model -> every response matches and ce_o is never asserted without an accept.
